pipeline_control: RTL and testbench

PIPELINE_CONTROL -- requirements
Module: pipeline_control

---
 rtl/pipeline_control.sv | 171 +++++++++++++++++
 tb/tb_pipeline_control.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_control.sv
// Pipeline control: stalls, bubbles and flushes for a five-stage pipeline.
// Freezes the whole pipeline while instruction or data memory is busy,
// inserts one bubble on a load-use hazard and flushes IF/ID and ID/EX on a
// taken branch.
// Optional feature macro: PIPELINE_PERF_COUNTERS_EN adds the stall_count and
// flush_count performance counter ports.
module pipeline_control #(
  parameter int COUNTER_WIDTH = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read_enable,
  input  logic       ex_branch_taken,
  input  logic       mem_access,
  input  logic       inst_mem_ack,
  input  logic       data_mem_ack,
  output logic       inst_mem_en,
  output logic       data_mem_en,
  output logic       pc_en,
  output logic       if_id_en,
  output logic       id_ex_en,
  output logic       ex_mem_en,
  output logic       mem_wb_en,
  output logic       if_id_flush,
  output logic       id_ex_flush
`ifdef PIPELINE_PERF_COUNTERS_EN
  ,
  output logic [COUNTER_WIDTH-1:0] stall_count,
  output logic [COUNTER_WIDTH-1:0] flush_count
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    WAIT_MEM = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   inst_done_q, inst_done_d;
  logic   data_done_q, data_done_d;

  logic active;
  logic inst_ok;
  logic data_ok;
  logic advance;
  logic load_use;

  // A zero-width counter makes no sense; the empty block only names the fault.
  if (COUNTER_WIDTH < 1) begin : g_invalid_counter_width
  end

  // Memory requests stay up until their ack has been seen in this transaction.
  always_comb begin
    active      = (state_q == RUN) || (state_q == WAIT_MEM);
    inst_mem_en = active && !inst_done_q;
    data_mem_en = active && mem_access && !data_done_q;
    inst_ok     = inst_done_q || (inst_mem_en && inst_mem_ack);
    data_ok     = !mem_access || data_done_q || (data_mem_en && data_mem_ack);
    advance     = active && inst_ok && data_ok;
    load_use    = ex_mem_read_enable && (ex_rd != 5'd0) &&
                  ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  end

  // Pipeline register enables and bubbles; a frozen pipeline drives all zero.
  always_comb begin
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    id_ex_en    = 1'b0;
    ex_mem_en   = 1'b0;
    mem_wb_en   = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (advance) begin
      id_ex_en  = 1'b1;
      ex_mem_en = 1'b1;
      mem_wb_en = 1'b1;
      if (ex_branch_taken) begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        id_ex_flush = 1'b1;
      end else begin
        pc_en    = 1'b1;
        if_id_en = 1'b1;
      end
    end
  end

  // Next state and the per-transaction ack flags.
  always_comb begin
    state_d     = state_q;
    inst_done_d = inst_done_q;
    data_done_d = data_done_q;
    case (state_q)
      IDLE: begin
        state_d = RUN;
      end
      RUN, WAIT_MEM: begin
        if (advance) begin
          inst_done_d = 1'b0;
          data_done_d = 1'b0;
          state_d     = RUN;
        end else begin
          if (inst_mem_en && inst_mem_ack) begin
            inst_done_d = 1'b1;
          end
          if (data_mem_en && data_mem_ack) begin
            data_done_d = 1'b1;
          end
          state_d = WAIT_MEM;
        end
      end
      default: begin
        state_d     = IDLE;
        inst_done_d = 1'b0;
        data_done_d = 1'b0;
      end
    endcase
  end

  // State and flag registers; reset abandons any outstanding request.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      inst_done_q <= 1'b0;
      data_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      inst_done_q <= inst_done_d;
      data_done_q <= data_done_d;
    end
  end

`ifdef PIPELINE_PERF_COUNTERS_EN
  logic [COUNTER_WIDTH-1:0] stall_count_q, stall_count_d;
  logic [COUNTER_WIDTH-1:0] flush_count_q, flush_count_d;

  // Stalls are frozen cycles plus load-use bubbles; flushes are applied branches.
  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (active && (!advance || (load_use && !ex_branch_taken))) begin
      stall_count_d = stall_count_q + COUNTER_WIDTH'(1);
    end
    if (advance && ex_branch_taken) begin
      flush_count_d = flush_count_q + COUNTER_WIDTH'(1);
    end
  end

  // Counter registers wrap naturally at their width.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_pipeline_control.sv
// Testbench for pipeline_control: directed scenarios followed by random
// traffic, every cycle compared against a behavioural model of the rules.
module tb_pipeline_control;

  localparam int TB_CW = 4;

  logic       clock = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       ex_mem_read_enable, ex_branch_taken, mem_access;
  logic       inst_mem_ack, data_mem_ack;
  logic       inst_mem_en, data_mem_en;
  logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic       if_id_flush, id_ex_flush;
`ifdef PIPELINE_PERF_COUNTERS_EN
  logic [TB_CW-1:0] stall_count, flush_count;
`endif

  int assert_count = 0;
  int fail_count   = 0;

  // Behavioural model: has the pipeline started, which acks are already banked.
  bit m_idle;
  bit m_inst_got;
  bit m_data_got;
  int unsigned m_stalls;
  int unsigned m_flushes;

  pipeline_control #(.COUNTER_WIDTH(TB_CW)) dut (
    .clock              (clock),
    .reset              (rst_n),
    .id_rs1             (id_rs1),
    .id_rs2             (id_rs2),
    .ex_rd              (ex_rd),
    .ex_mem_read_enable (ex_mem_read_enable),
    .ex_branch_taken    (ex_branch_taken),
    .mem_access         (mem_access),
    .inst_mem_ack       (inst_mem_ack),
    .data_mem_ack       (data_mem_ack),
    .inst_mem_en        (inst_mem_en),
    .data_mem_en        (data_mem_en),
    .pc_en              (pc_en),
    .if_id_en           (if_id_en),
    .id_ex_en           (id_ex_en),
    .ex_mem_en          (ex_mem_en),
    .mem_wb_en          (mem_wb_en),
    .if_id_flush        (if_id_flush),
    .id_ex_flush        (id_ex_flush)
`ifdef PIPELINE_PERF_COUNTERS_EN
    ,
    .stall_count        (stall_count),
    .flush_count        (flush_count)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clock = ~clock;

  function automatic bit want_inst();
    return !m_idle && !m_inst_got;
  endfunction

  function automatic bit want_data();
    return !m_idle && mem_access && !m_data_got;
  endfunction

  function automatic bit model_advance();
    bit have_inst;
    bit have_data;
    have_inst = m_inst_got || (want_inst() && inst_mem_ack);
    have_data = !mem_access || m_data_got || (want_data() && data_mem_ack);
    return !m_idle && have_inst && have_data;
  endfunction

  function automatic bit model_hazard();
    return ex_mem_read_enable && (ex_rd != 5'd0) && (ex_rd == id_rs1 || ex_rd == id_rs2);
  endfunction

  task automatic modelReset();
    m_idle     = 1'b1;
    m_inst_got = 1'b0;
    m_data_got = 1'b0;
    m_stalls   = 0;
    m_flushes  = 0;
  endtask

  // Advance the model by one rising edge using the current inputs.
  task automatic modelClock();
    bit adv;
    adv = model_advance();
    if (m_idle) begin
      m_idle = 1'b0;
    end else begin
      if (!adv || (model_hazard() && !ex_branch_taken)) m_stalls = (m_stalls + 1) % (1 << TB_CW);
      if (adv && ex_branch_taken) m_flushes = (m_flushes + 1) % (1 << TB_CW);
      if (adv) begin
        m_inst_got = 1'b0;
        m_data_got = 1'b0;
      end else begin
        if (want_inst() && inst_mem_ack) m_inst_got = 1'b1;
        if (want_data() && data_mem_ack) m_data_got = 1'b1;
      end
    end
  endtask

  // Compare every output group with what the model predicts right now.
  task automatic checkOutput(input string tag);
    logic [4:0] exp_en;
    logic [1:0] exp_fl;
    logic [1:0] exp_mem;
    exp_mem = {want_inst(), want_data()};
    if (!model_advance()) begin
      exp_en = 5'b00000;
      exp_fl = 2'b00;
    end else if (ex_branch_taken) begin
      exp_en = 5'b11111;
      exp_fl = 2'b11;
    end else if (model_hazard()) begin
      exp_en = 5'b00111;
      exp_fl = 2'b01;
    end else begin
      exp_en = 5'b11111;
      exp_fl = 2'b00;
    end
    assert_count++;
    assert ({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} === exp_en) else begin
      fail_count++;
      $error("[TB] FAIL %s enables observed=%b expected=%b", tag,
             {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, exp_en);
    end
    assert_count++;
    assert ({if_id_flush, id_ex_flush} === exp_fl) else begin
      fail_count++;
      $error("[TB] FAIL %s flushes observed=%b expected=%b", tag, {if_id_flush, id_ex_flush}, exp_fl);
    end
    assert_count++;
    assert ({inst_mem_en, data_mem_en} === exp_mem) else begin
      fail_count++;
      $error("[TB] FAIL %s mem_requests observed=%b expected=%b", tag, {inst_mem_en, data_mem_en}, exp_mem);
    end
`ifdef PIPELINE_PERF_COUNTERS_EN
    assert_count++;
    assert (stall_count === TB_CW'(m_stalls)) else begin
      fail_count++;
      $error("[TB] FAIL %s stall_count observed=%0d expected=%0d", tag, stall_count, m_stalls);
    end
    assert_count++;
    assert (flush_count === TB_CW'(m_flushes)) else begin
      fail_count++;
      $error("[TB] FAIL %s flush_count observed=%0d expected=%0d", tag, flush_count, m_flushes);
    end
`endif
  endtask

  // One cycle: check mid-cycle, step the model, land just after the next edge.
  task automatic applyStimulus(input string tag);
    @(negedge clock);
    checkOutput(tag);
    modelClock();
    @(posedge clock);
    #1;
  endtask

  task automatic setInputs(input bit ia, input bit da, input bit ma,
                           input bit rd_en, input bit br,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    inst_mem_ack       = ia;
    data_mem_ack       = da;
    mem_access         = ma;
    ex_mem_read_enable = rd_en;
    ex_branch_taken    = br;
    ex_rd              = rd;
    id_rs1             = rs1;
    id_rs2             = rs2;
  endtask

  initial begin
    rst_n = 1'b0;
    setInputs(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    modelReset();
    #1;
    checkOutput("reset_at_time0");

    // Release with acks tied high and no hazards: one Idle cycle, then run.
    @(posedge clock);
    #1;
    rst_n = 1'b1;
    setInputs(1, 1, 0, 0, 0, 5'd0, 5'd1, 5'd2);
    applyStimulus("idle_after_release");
    repeat (3) applyStimulus("free_run");

    // Load-use on rs2 gives one bubble, then normal flow.
    setInputs(1, 1, 0, 1, 0, 5'd5, 5'd7, 5'd5);
    applyStimulus("load_use_bubble");
    setInputs(1, 1, 0, 0, 0, 5'd5, 5'd7, 5'd5);
    applyStimulus("after_load_use");

    // Load-use on rs1 with x0 destination must not stall.
    setInputs(1, 1, 0, 1, 0, 5'd0, 5'd0, 5'd3);
    applyStimulus("load_to_x0_no_stall");

    // Branch wins over a simultaneous load-use.
    setInputs(1, 1, 0, 1, 1, 5'd5, 5'd5, 5'd9);
    applyStimulus("branch_over_load_use");
    setInputs(1, 1, 0, 0, 0, 5'd0, 5'd1, 5'd2);
    applyStimulus("after_branch");

    // Data ack three cycles late: three frozen cycles, branch held until advance.
    setInputs(1, 0, 1, 0, 1, 5'd0, 5'd1, 5'd2);
    applyStimulus("data_wait_1");
    setInputs(0, 0, 1, 0, 1, 5'd0, 5'd1, 5'd2);
    applyStimulus("data_wait_2");
    applyStimulus("data_wait_3");
    setInputs(0, 1, 1, 0, 1, 5'd0, 5'd1, 5'd2);
    applyStimulus("data_ack_advance");

    // Enter WaitMem, then pull reset mid-cycle and check without a clock edge.
    setInputs(1, 0, 1, 0, 0, 5'd0, 5'd1, 5'd2);
    applyStimulus("wait_before_reset_1");
    applyStimulus("wait_before_reset_2");
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("async_reset");
    @(posedge clock);
    #1;
    checkOutput("reset_held");

    // After release the old banked acks must be gone; then 17 forced stalls.
    rst_n = 1'b1;
    setInputs(1, 0, 1, 0, 0, 5'd0, 5'd1, 5'd2);
    applyStimulus("idle_after_reset2");
    repeat (17) applyStimulus("forced_stall");
    setInputs(1, 1, 1, 0, 0, 5'd0, 5'd1, 5'd2);
    applyStimulus("release_stall");

    // Random traffic with sparse acks and frequent register collisions.
    repeat (400) begin
      setInputs($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 1) != 0,
                $urandom_range(0, 1) != 0, $urandom_range(0, 4) == 0,
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      applyStimulus("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
